// File: rtl/calc_pkg.sv
// Shared constants and state type for the calculator key sequencer.
// Optional feature macro used by the sequencer: CALC_SEQ_CHAIN_EN.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'h10;
    localparam logic [4:0] KEY_SUB = 5'h11;
    localparam logic [4:0] KEY_MUL = 5'h12;
    localparam logic [4:0] KEY_DIV = 5'h13;
    localparam logic [4:0] KEY_EQ  = 5'h14;
    localparam logic [4:0] KEY_CLR = 5'h15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] RES_DIV0 = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        HAVE_A,
        HAVE_OP,
        HAVE_B,
        EXEC,
        DONE
    } calc_seq_state_t;

endpackage

// File: rtl/calc_key_decode.sv
// Combinational classifier for keypad codes: digit / operator / equals / clear.
module calc_key_decode
    import calc_pkg::*;
(
    input  logic [4:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_eq,
    output logic       is_clr,
    output logic [1:0] op
);

    // Operators occupy 0x10..0x13, so the low two bits are the op encoding.
    assign is_digit = ~key_code[4];
    assign is_op    = (key_code[4:2] == 3'b100);
    assign is_eq    = (key_code == KEY_EQ);
    assign is_clr   = (key_code == KEY_CLR);
    assign op       = key_code[1:0];

endmodule

// File: rtl/calc_key_sequencer.sv
// Key-event sequencer driving the calculator operands and latching its result.
// Build option: define CALC_SEQ_CHAIN_EN to chain an operator key onto the last result.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned CALC_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic       key_ready,
    output logic [3:0] calc_a,
    output logic [3:0] calc_b,
    output logic [1:0] calc_op,
    input  logic [7:0] calc_result,
    output logic [7:0] res_out,
    output logic       res_valid,
    output logic       err
);

    localparam logic [3:0] LAT_LAST = 4'(CALC_LAT - 1);

    calc_seq_state_t state, state_nxt;
    logic [3:0] calc_a_nxt, calc_b_nxt;
    logic [1:0] calc_op_nxt;
    logic [7:0] res_out_nxt;
    logic       res_valid_nxt, err_nxt;
    logic [3:0] lat_cnt, lat_cnt_nxt;

    logic       is_digit, is_op, is_eq, is_clr;
    logic [1:0] key_op;
    logic       accept;

    calc_key_decode u_decode (
        .key_code (key_code),
        .is_digit (is_digit),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr),
        .op       (key_op)
    );

    assign key_ready = (state != EXEC);
    assign accept    = key_valid && key_ready;

    // NOTE: every *_nxt gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_nxt     = state;
        calc_a_nxt    = calc_a;
        calc_b_nxt    = calc_b;
        calc_op_nxt   = calc_op;
        res_out_nxt   = res_out;
        res_valid_nxt = res_valid;
        err_nxt       = err;
        lat_cnt_nxt   = lat_cnt;

        unique case (state)
            IDLE: begin
                if (accept && is_digit) begin
                    calc_a_nxt = key_code[3:0];
                    state_nxt  = HAVE_A;
                end
            end
            HAVE_A: begin
                if (accept && is_digit) begin
                    calc_a_nxt = key_code[3:0];
                end else if (accept && is_op) begin
                    calc_op_nxt = key_op;
                    state_nxt   = HAVE_OP;
                end
            end
            HAVE_OP: begin
                if (accept && is_op) begin
                    calc_op_nxt = key_op;
                end else if (accept && is_digit) begin
                    calc_b_nxt = key_code[3:0];
                    state_nxt  = HAVE_B;
                end
            end
            HAVE_B: begin
                if (accept && is_digit) begin
                    calc_b_nxt = key_code[3:0];
                end else if (accept && is_eq) begin
                    if (calc_op == OP_DIV && calc_b == 4'd0) begin
                        res_out_nxt   = RES_DIV0;
                        res_valid_nxt = 1'b1;
                        err_nxt       = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        lat_cnt_nxt = 4'd0;
                        state_nxt   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (lat_cnt == LAT_LAST) begin
                    res_out_nxt   = calc_result;
                    res_valid_nxt = 1'b1;
                    err_nxt       = 1'b0;
                    state_nxt     = DONE;
                end else if (lat_cnt != 4'hF) begin
                    lat_cnt_nxt = lat_cnt + 4'd1;
                end
            end
            DONE: begin
                if (accept && is_digit) begin
                    calc_a_nxt    = key_code[3:0];
                    res_valid_nxt = 1'b0;
                    err_nxt       = 1'b0;
                    state_nxt     = HAVE_A;
                end
`ifdef CALC_SEQ_CHAIN_EN
                else if (accept && is_op && !err) begin
                    calc_a_nxt    = res_out[3:0];
                    calc_op_nxt   = key_op;
                    res_valid_nxt = 1'b0;
                    state_nxt     = HAVE_OP;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        // Clear wins over anything above; accept is already low in EXEC.
        if (accept && is_clr) begin
            state_nxt     = IDLE;
            calc_a_nxt    = 4'd0;
            calc_b_nxt    = 4'd0;
            calc_op_nxt   = OP_ADD;
            res_out_nxt   = 8'd0;
            res_valid_nxt = 1'b0;
            err_nxt       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            calc_a    <= 4'd0;
            calc_b    <= 4'd0;
            calc_op   <= OP_ADD;
            res_out   <= 8'd0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            lat_cnt   <= 4'd0;
        end else begin
            state     <= state_nxt;
            calc_a    <= calc_a_nxt;
            calc_b    <= calc_b_nxt;
            calc_op   <= calc_op_nxt;
            res_out   <= res_out_nxt;
            res_valid <= res_valid_nxt;
            err       <= err_nxt;
            lat_cnt   <= lat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: two instances (CALC_LAT=1 and 3) with a calculator model.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic       kv1, kv3;
    logic [4:0] kc1, kc3;
    logic       kr1, kr3;
    logic [3:0] a1, b1, a3, b3;
    logic [1:0] op1, op3;
    logic [7:0] cr1, cr3, res1, res3;
    logic       rv1, rv3, err1, err3;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q1[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;

    // Stand-in for the calculator datapath owned by the parent.
    function automatic logic [7:0] calc_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return {4'd0, a} + {4'd0, b};
            2'b01:   return {4'd0, a} - {4'd0, b};
            2'b10:   return {4'd0, a} * {4'd0, b};
            default: return (b == 4'd0) ? 8'd0 : {4'd0, a} / {4'd0, b};
        endcase
    endfunction

    assign cr1 = calc_model(a1, b1, op1);
    assign cr3 = calc_model(a3, b3, op3);

    calc_key_sequencer #(.CALC_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv1), .key_code(kc1), .key_ready(kr1),
        .calc_a(a1), .calc_b(b1), .calc_op(op1), .calc_result(cr1),
        .res_out(res1), .res_valid(rv1), .err(err1)
    );

    calc_key_sequencer #(.CALC_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv3), .key_code(kc3), .key_ready(kr3),
        .calc_a(a3), .calc_b(b3), .calc_op(op3), .calc_result(cr3),
        .res_out(res3), .res_valid(rv3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic key(input int which, input logic [4:0] c);
        @(negedge clk);
        if (which == 3) begin kv3 = 1'b1; kc3 = c; end
        else            begin kv1 = 1'b1; kc1 = c; end
        @(posedge clk);
        #1;
        kv1 = 1'b0;
        kv3 = 1'b0;
    endtask

    task automatic check_idle(input int which, input string tag);
        if (which == 3) begin
            check({tag, " ready"}, kr3, 1);
            check({tag, " a/b/op"}, {a3, b3, op3}, 0);
            check({tag, " res/rv/err"}, {res3, rv3, err3}, 0);
        end else begin
            check({tag, " ready"}, kr1, 1);
            check({tag, " a/b/op"}, {a1, b1, op1}, 0);
            check({tag, " res/rv/err"}, {res1, rv1, err1}, 0);
        end
    endtask

    // Called one step after the EQ edge; checks latency, busy cycles and the popped result.
    task automatic wait_res(input int which, input int lat, input string tag);
        int   cyc  = 0;
        int   busy = 0;
        logic got  = 1'b0;
        logic [7:0] exp;
        if (!((which == 3) ? kr3 : kr1)) busy++;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((which == 3) ? rv3 : rv1) begin
                got = 1'b1;
                kv1 = 1'b0;
                kv3 = 1'b0;
            end
            if (!((which == 3) ? kr3 : kr1)) busy++;
        end
        check({tag, " res_valid seen"}, got, 1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " ready-low cycles"}, busy, lat);
        if (which == 3) begin
            check({tag, " queue"}, q3.size(), 1);
            if (q3.size() > 0) begin exp = q3.pop_front(); check({tag, " res_out"}, res3, exp); end
            check({tag, " err"}, err3, 0);
        end else begin
            check({tag, " queue"}, q1.size(), 1);
            if (q1.size() > 0) begin exp = q1.pop_front(); check({tag, " res_out"}, res1, exp); end
            check({tag, " err"}, err1, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp;
        logic       seen;
        rst_n = 1'b0;
        kv1 = 1'b0; kc1 = 5'd0;
        kv3 = 1'b0; kc3 = 5'd0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle(1, "reset d1");
        check_idle(3, "reset d3");

        // Unlisted and unknown keys in IDLE are dropped.
        key(1, KEY_EQ);
        key(1, 5'h1F);
        key(1, KEY_ADD);
        check_idle(1, "idle ignore");

        // 3 + 4, CALC_LAT=1
        key(1, 5'h3);    check("t1 a", a1, 4'h3);
        key(1, KEY_ADD); check("t1 op", op1, OP_ADD);
        key(1, 5'h4);    check("t1 b", b1, 4'h4);
        key(1, KEY_EQ);  q1.push_back(8'h07);
        check("t1 exec ready", kr1, 0);
        wait_res(1, 1, "t1");

        // F * F, CALC_LAT=3, CLR held through EXEC must not be taken
        key(3, 5'hF); key(3, KEY_MUL); key(3, 5'hF); key(3, KEY_EQ);
        q3.push_back(8'hE1);
        @(negedge clk);
        kv3 = 1'b1; kc3 = KEY_CLR;
        wait_res(3, 3, "t2");
        check("t2 operands held", {a3, b3, op3}, {4'hF, 4'hF, OP_MUL});

        // 9 / 0: immediate error result, no EXEC
        key(1, 5'h9); key(1, KEY_DIV); key(1, 5'h0); key(1, KEY_EQ);
        q1.push_back(RES_DIV0);
        check("t3 ready", kr1, 1);
        check("t3 rv/err", {rv1, err1}, 2'b11);
        exp = q1.pop_front();
        check("t3 res_out", res1, exp);
        key(1, 5'h2);
        check("t3 after digit", {a1, rv1, err1}, {4'h2, 2'b00});

        // last digit wins, operator override, then CLR
        key(1, 5'h5);    check("t4 a replace", a1, 4'h5);
        key(1, KEY_SUB); check("t4 op sub", op1, OP_SUB);
        key(1, KEY_MUL); check("t4 op override", op1, OP_MUL);
        key(1, 5'h2);    check("t4 b", b1, 4'h2);
        key(1, KEY_CLR);
        check_idle(1, "t4 clr");
        key(1, 5'h5); key(1, KEY_MUL); key(1, 5'h2); key(1, KEY_EQ);
        q1.push_back(8'h0A);
        wait_res(1, 1, "t4");

        // 6 + 7, then an operator in DONE
        key(1, 5'h6); key(1, KEY_ADD); key(1, 5'h7); key(1, KEY_EQ);
        q1.push_back(8'h0D);
        wait_res(1, 1, "t5");
        key(1, KEY_ADD);
`ifdef CALC_SEQ_CHAIN_EN
        check("t5 chain a", a1, 4'hD);
        check("t5 chain op/rv", {op1, rv1}, {OP_ADD, 1'b0});
        key(1, 5'h1); key(1, KEY_EQ);
        q1.push_back(8'h0E);
        wait_res(1, 1, "t5 chain");
`else
        check("t5 op ignored a", a1, 4'h6);
        check("t5 op ignored res", {res1, rv1}, {8'h0D, 1'b1});
`endif

        // Async reset in the middle of EXEC
        key(3, 5'h1); key(3, KEY_ADD); key(3, 5'h1); key(3, KEY_EQ);
        check("t6 in exec", kr3, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle(3, "t6 async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rv3) seen = 1'b1;
        end
        check("t6 no late result", seen, 0);
        check_idle(3, "t6 after");

        check("queue d1 drained", q1.size(), 0);
        check("queue d3 drained", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Sequential command-entry front end for the 4-bit calculator datapath. It accepts a stream of one-cycle key events: operand digit, operator, digit, then equals. It drives the calculator's `A`, `B` and `op` inputs from registers, samples the 8-bit `result` a fixed number of cycles later and holds it for display. It is the initiator side of the calculator interface, sitting between keypad decode and the arithmetic block.

## Interface
- `CALC_LAT`, default 1: cycles from the operands being stable (EXEC entry) to the `result` sample; range 1–15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `key_valid` input 1: key event present this cycle.
- `key_code` input 5: key value.
  - 0x00–0x0F: digit.
  - 0x10 ADD, 0x11 SUB, 0x12 MUL, 0x13 DIV.
  - 0x14 EQ, 0x15 CLR.
  - Other codes are ignored.
- `key_ready` output 1: key accepted when `key_valid && key_ready` at a rising edge.
- `calc_a` output 4: registered operand A to the calculator.
- `calc_b` output 4: registered operand B to the calculator.
- `calc_op` output 2: registered op: 00 add, 01 sub, 10 mul, 11 div.
- `calc_result` input 8: combinational result returned from the calculator.
- `res_out` output 8: latched result.
- `res_valid` output 1: `res_out` holds a fresh result.
- `err` output 1: divide-by-zero flagged on the last EQ.

## Operation
- States:
  - IDLE: waiting for A.
  - HAVE_A: waiting for the operator.
  - HAVE_OP: waiting for B.
  - HAVE_B: waiting for EQ.
  - EXEC: counting to the result sample.
  - DONE: holding the result.
- Transitions on accepted keys:
  - IDLE, digit d: `calc_a`=d, go to HAVE_A.
  - HAVE_A:
    - digit: replaces `calc_a` (last digit wins).
    - operator: load `calc_op`, go to HAVE_OP.
  - HAVE_OP:
    - operator: replaces `calc_op`.
    - digit: `calc_b`=d, go to HAVE_B.
  - HAVE_B:
    - digit: replaces `calc_b`.
    - EQ with `calc_op`=11 and `calc_b`=0: go to DONE with `res_out`=0xFF, `err`=1, `res_valid`=1. No calculator sample is taken.
    - EQ otherwise: go to EXEC, clear the latency counter.
  - EXEC: after CALC_LAT cycles, `res_out` ← `calc_result`, `res_valid`=1, `err`=0, go to DONE.
  - DONE:
    - digit d: `calc_a`=d, `res_valid`=0, `err`=0, go to HAVE_A.
    - EQ: ignored.
    - operator: behaviour set by the macro in Configuration.
- Keys not listed for a state are consumed and ignored; state and outputs do not change.
- CLR in any state except EXEC returns to IDLE and zeroes `calc_a`, `calc_b`, `calc_op`, `res_out`, `res_valid` and `err`.
- Arithmetic is done entirely by the calculator; this block never modifies `calc_result` bits.

## Timing
- Reset values: state IDLE, `key_ready`=1, `calc_a`=0, `calc_b`=0, `calc_op`=0, `res_out`=0, `res_valid`=0, `err`=0, latency counter 0.
- Reset asserted mid-EXEC aborts the operation immediately and discards any pending sample.
- `key_ready` is 0 for exactly the cycles spent in EXEC and 1 in every other state. Keys presented during EXEC, including CLR, are not accepted.
- All outputs are registers and change only on the clock edge that accepts a key or completes EXEC.
- EQ accepted at edge n:
  - `calc_*` are already stable.
  - `calc_result` is sampled at edge n+CALC_LAT.
  - `res_valid` rises after that edge, giving a total EQ-to-`res_valid` latency of CALC_LAT cycles.
- `calc_a`, `calc_b` and `calc_op` are held constant throughout EXEC.
- The latency counter is 4 bits wide and saturates; it does not wrap.

## Configuration
- `CALC_SEQ_CHAIN_EN` defined:
  - An operator key in DONE with `err`=0 loads `calc_a` ← `res_out[3:0]` (truncation of the upper nibble is intended) and `calc_op` ← operator.
  - It clears `res_valid` and goes to HAVE_OP.
  - An operator key in DONE with `err`=1 is ignored.
- `CALC_SEQ_CHAIN_EN` undefined: operator keys in DONE are ignored.

## Structure
- Shared package `calc_pkg` holds:
  - the key code localparams (KEY_ADD … KEY_CLR);
  - the op encoding constants (OP_ADD=2'b00 … OP_DIV=2'b11);
  - the state enum typedef `calc_seq_state_t`.
- The calculator module stays a separate instance owned by the parent.
- One sub-module: `calc_key_decode`. It is combinational and classifies `key_code` into `is_digit`, `is_op`, `is_eq` and `is_clr`, plus a 2-bit op field.

## Test plan
- Keys 3, ADD, 4, EQ, CALC_LAT=1 -> `calc_a`=3, `calc_op`=00, `calc_b`=4; `res_out`=0x07 and `res_valid`=1 one cycle after EQ; `key_ready`=0 for exactly 1 cycle.
- Keys F, MUL, F, EQ, CALC_LAT=3 -> `res_out`=0xE1 (225) three cycles after EQ; keys held during EXEC are not accepted.
- Keys 9, DIV, 0, EQ -> `res_out`=0xFF, `err`=1, DONE with no EXEC cycle; then digit 2 -> `err`=0, `res_valid`=0, `calc_a`=2.
- Keys 5, SUB, SUB→MUL override, 2, CLR -> all outputs zero, IDLE; then 5, MUL, 2, EQ -> 0x0A.
- With `CALC_SEQ_CHAIN_EN`: keys 6, ADD, 7, EQ (0x0D), then ADD, 1, EQ -> `calc_a`=0xD, `res_out`=0x0E. Without the macro, the second ADD is ignored.
- `rst_n` pulsed low during EXEC -> all outputs return to reset values asynchronously; no `res_valid` follows.
